// File: rtl/led_frame_sched_pkg.sv
// led_matrix_pkg: shared types and constants for the LED frame scheduler.
//   sched_state_t   - scheduler FSM state encoding
//   NUM_SRC         - number of frame sources (scroller, overlay)
//   SHIFT_W/MAX     - scroll shift register width and wrap point
//   LED_COUNT       - LEDs per strip frame (serializer side)
//   DEFAULT_TIMEOUT - default watchdog limit for an active frame
//   rr_pick()       - round-robin source pick for two requesters
package led_matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_ACTIVE = 2'd2
  } sched_state_t;

  localparam int NUM_SRC         = 2;
  localparam int SHIFT_W         = 3;
  localparam int SHIFT_MAX       = 7;
  localparam int LED_COUNT       = 64;
  localparam int DEFAULT_TIMEOUT = 8192;

  // Only meaningful when at least one request bit is set. With both
  // requesting, the source that did not win last time takes the frame.
  function automatic logic rr_pick(input logic [NUM_SRC-1:0] req,
                                   input logic               last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/led_frame_sched_if.sv
// led_frame_sched_if: frame request / serializer handshake bundle.
//   req       - level frame requests, bit0 scroller, bit1 overlay
//   grant     - one-hot grant, held for the whole frame
//   ser_start - one-cycle frame start pulse to the serializer
//   ser_src   - granted source index
//   ser_busy  - serializer busy
//   ser_done  - one-cycle end-of-frame pulse from the serializer
// master: scheduler side. slave: requesters + serializer side.
interface led_frame_sched_if;
  import led_matrix_pkg::*;

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] grant;
  logic               ser_start;
  logic               ser_src;
  logic               ser_busy;
  logic               ser_done;

  modport master (
    input  req,
    input  ser_busy,
    input  ser_done,
    output grant,
    output ser_start,
    output ser_src
  );

  modport slave (
    output req,
    output ser_busy,
    output ser_done,
    input  grant,
    input  ser_start,
    input  ser_src
  );

endinterface

// File: rtl/led_frame_sched_frame_tick_gen.sv
// frame_tick_gen: frame-period prescaler and frame_due latch.
//   clk, reset      - clock, synchronous active-high reset
//   i_frame_div     - cycles between frame ticks (0 behaves as 1)
//   i_grant_issue   - scheduler is issuing a grant this cycle
//   o_frame_due     - a frame tick has occurred and not yet been consumed
module frame_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] i_frame_div,
  input  logic             i_grant_issue,
  output logic             o_frame_due
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_due;
  logic [DIV_W-1:0] w_div_last;
  logic             w_wrap;

  // Compare with >= so that shrinking the divider below the current count
  // wraps on the very next edge instead of running through the full range.
  assign w_div_last = (i_frame_div == '0) ? '0 : i_frame_div - 1'b1;
  assign w_wrap     = (r_cnt >= w_div_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_due <= 1'b0;
    end else begin
      if (w_wrap) r_cnt <= '0;
      else        r_cnt <= r_cnt + 1'b1;

      // Ticks that arrive while a frame is pending are absorbed; a tick
      // coinciding with the grant is consumed by that grant.
      if (i_grant_issue) r_due <= 1'b0;
      else if (w_wrap)   r_due <= 1'b1;
    end
  end

  assign o_frame_due = r_due;

endmodule

// File: rtl/led_frame_sched.sv
// led_frame_sched: frame scheduler for an LED matrix strip.
//   clk, reset   - clock, synchronous active-high reset
//   frame_div    - clk cycles between frame ticks (0 behaves as 1)
//   scroll_en    - allow shift advance after scroller (source 0) frames
//   ser_if       - request / serializer handshake (master side)
//   shift        - scroll shift 0..7, stable while a frame is active
//   digit_sel    - leading digit index, toggles when shift wraps
//   frame_cnt    - completed-frame counter, wraps 255->0
//   timeout_err  - sticky serializer timeout flag
//
// state     | meaning
// ST_IDLE   | waiting for frame tick, a request and a free serializer
// ST_ISSUE  | grant just registered, ser_start high this cycle
// ST_ACTIVE | frame in flight, waiting for ser_done or watchdog expiry
module led_frame_sched
  import led_matrix_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DIV_W-1:0]   frame_div,
  input  logic               scroll_en,
  led_frame_sched_if.master  ser_if,
  output logic [SHIFT_W-1:0] shift,
  output logic               digit_sel,
  output logic [7:0]         frame_cnt,
  output logic               timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  sched_state_t       r_state;
  sched_state_t       w_state_nxt;

  logic [NUM_SRC-1:0] r_grant;
  logic               r_ser_start;
  logic               r_ser_src;
  logic               r_last;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_digit_sel;
  logic [7:0]         r_frame_cnt;
  logic               r_timeout_err;
  logic [WD_W-1:0]    r_wd;

  logic               w_frame_due;
  logic               w_issue;
  logic               w_complete;
  logic               w_abort;
  logic               w_win_src;
  logic               w_wd_tc;

  frame_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk           (clk),
    .reset         (reset),
    .i_frame_div   (frame_div),
    .i_grant_issue (w_issue),
    .o_frame_due   (w_frame_due)
  );

  assign w_win_src = rr_pick(ser_if.req, r_last);
  // Watchdog is a down-counter loaded on the ISSUE->ACTIVE edge, so the
  // terminal count is reached TIMEOUT cycles into ACTIVE.
  assign w_wd_tc   = (r_wd == '0);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_frame_due && (|ser_if.req) && !ser_if.ser_busy) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // A done arriving together with the watchdog expiry is a normal
        // completion.
        if (ser_if.ser_done) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_wd_tc) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant       <= '0;
      r_ser_start   <= 1'b0;
      r_ser_src     <= 1'b0;
      r_last        <= 1'b1;
      r_shift       <= '0;
      r_digit_sel   <= 1'b0;
      r_frame_cnt   <= '0;
      r_timeout_err <= 1'b0;
      r_wd          <= '0;
    end else begin
      r_ser_start <= w_issue;

      if (w_issue) begin
        r_grant   <= w_win_src ? 2'b10 : 2'b01;
        r_ser_src <= w_win_src;
        r_last    <= w_win_src;
      end else if (w_complete || w_abort) begin
        r_grant <= '0;
      end

      if (r_state == ST_ISSUE) begin
        r_wd <= WD_W'(TIMEOUT);
      end else if ((r_state == ST_ACTIVE) && !w_wd_tc) begin
        r_wd <= r_wd - 1'b1;
      end

      if (w_complete) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
        if (!r_ser_src && scroll_en) begin
          if (r_shift == SHIFT_W'(SHIFT_MAX)) begin
            r_shift     <= '0;
            r_digit_sel <= ~r_digit_sel;
          end else begin
            r_shift <= r_shift + 1'b1;
          end
        end
      end

      if (w_abort) r_timeout_err <= 1'b1;
    end
  end

  assign ser_if.grant     = r_grant;
  assign ser_if.ser_start = r_ser_start;
  assign ser_if.ser_src   = r_ser_src;
  assign shift            = r_shift;
  assign digit_sel        = r_digit_sel;
  assign frame_cnt        = r_frame_cnt;
  assign timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_led_frame_sched.sv
// tb_led_frame_sched: directed self-checking bench for led_frame_sched.
module tb_led_frame_sched;

  logic        clk;
  logic        reset;
  logic [15:0] frame_div;
  logic        scroll_en;
  logic [2:0]  shift;
  logic        digit_sel;
  logic [7:0]  frame_cnt;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  led_frame_sched_if ser_if ();

  led_frame_sched #(
    .DIV_W   (16),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_div   (frame_div),
    .scroll_en   (scroll_en),
    .ser_if      (ser_if),
    .shift       (shift),
    .digit_sel   (digit_sel),
    .frame_cnt   (frame_cnt),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: sim time limit reached, expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(ser_if.grant), 0);
    chk({tag, "_start"}, 32'(ser_if.ser_start), 0);
    chk({tag, "_src"},   32'(ser_if.ser_src), 0);
    chk({tag, "_shift"}, 32'(shift), 0);
    chk({tag, "_digit"}, 32'(digit_sel), 0);
    chk({tag, "_fcnt"},  32'(frame_cnt), 0);
    chk({tag, "_terr"},  32'(timeout_err), 0);
  endtask

  // Returns the number of edges waited until ser_start is seen.
  task automatic wait_start(output int waited);
    waited = 0;
    while (!ser_if.ser_start && waited < 200) begin
      tick();
      waited++;
    end
    if (!ser_if.ser_start) chk("start_wait_expired", 0, 1);
  endtask

  // ser_done is driven dly cycles after the ser_start cycle.
  task automatic run_frame(input int dly, output logic [1:0] g,
                           output int gcnt, output int scnt);
    int w;
    wait_start(w);
    g    = ser_if.grant;
    gcnt = 1;
    scnt = 1;
    for (int i = 0; i < dly; i++) begin
      tick();
      if (ser_if.grant == g) gcnt++;
      if (ser_if.ser_start)  scnt++;
    end
    ser_if.ser_done = 1'b1;
    tick();
    ser_if.ser_done = 1'b0;
    chk("grant_drop", 32'(ser_if.grant), 0);
  endtask

  initial begin
    logic [1:0] g;
    logic [1:0] exp_rr [4];
    int gcnt, scnt, w, n;

    exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;

    reset           = 1'b1;
    frame_div       = 16'd4;
    scroll_en       = 1'b1;
    ser_if.req      = 2'b00;
    ser_if.ser_busy = 1'b0;
    ser_if.ser_done = 1'b0;

    // reset values
    do_reset();
    check_reset_vals("rst");

    // basic frame, also prescaler latency: 4 counts then one IDLE edge
    ser_if.req = 2'b01;
    do_reset();
    wait_start(w);
    chk("first_start_lat", 32'(w), 5);
    run_frame(10, g, gcnt, scnt);
    ser_if.req = 2'b00;
    chk("basic_grant", 32'(g), 32'h1);
    chk("basic_gcnt",  32'(gcnt), 11);
    chk("basic_scnt",  32'(scnt), 1);
    chk("basic_fcnt",  32'(frame_cnt), 1);
    chk("basic_shift", 32'(shift), 1);

    // ser_done in IDLE is ignored
    ser_if.ser_done = 1'b1;
    tick();
    ser_if.ser_done = 1'b0;
    tick();
    chk("idle_done_fcnt", 32'(frame_cnt), 1);

    // round robin with both requesting
    ser_if.req = 2'b11;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_frame(2, g, gcnt, scnt);
      chk($sformatf("rr_grant%0d", k), 32'(g), 32'(exp_rr[k]));
    end
    ser_if.req = 2'b00;
    chk("rr_shift", 32'(shift), 2);
    chk("rr_fcnt",  32'(frame_cnt), 4);

    // scroll wrap
    frame_div  = 16'd1;
    ser_if.req = 2'b01;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      run_frame(1, g, gcnt, scnt);
      chk($sformatf("wrap_shift%0d", k), 32'(shift), 32'(k % 8));
      chk($sformatf("wrap_digit%0d", k), 32'(digit_sel), (k == 8) ? 1 : 0);
    end
    // scroll disabled: no advance
    scroll_en = 1'b0;
    run_frame(1, g, gcnt, scnt);
    ser_if.req = 2'b00;
    chk("noscroll_shift", 32'(shift), 0);
    chk("noscroll_digit", 32'(digit_sel), 1);
    chk("noscroll_fcnt",  32'(frame_cnt), 9);
    scroll_en = 1'b1;

    // timeout: req dropped mid-frame must not shorten it
    ser_if.req = 2'b01;
    do_reset();
    wait_start(w);
    ser_if.req = 2'b00;
    tick();
    n = 0;
    while (ser_if.grant != 2'b00 && n < 40) begin
      tick();
      n++;
    end
    chk("to_drop_cycles", 32'(n), 17);
    chk("to_err",   32'(timeout_err), 1);
    chk("to_fcnt",  32'(frame_cnt), 0);
    chk("to_shift", 32'(shift), 0);
    ser_if.req = 2'b01;
    run_frame(2, g, gcnt, scnt);
    ser_if.req = 2'b00;
    chk("to_after_fcnt", 32'(frame_cnt), 1);
    chk("to_sticky",     32'(timeout_err), 1);

    // busy holds off the grant; ser_done in ISSUE ignored; reset mid-frame
    frame_div       = 16'd2;
    ser_if.req      = 2'b01;
    ser_if.ser_busy = 1'b1;
    do_reset();
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ser_if.grant != 2'b00 || ser_if.ser_start) n++;
    end
    chk("busy_nogrant", 32'(n), 0);
    ser_if.ser_busy = 1'b0;
    wait_start(w);
    chk("busy_release_lat", 32'(w), 1);
    ser_if.ser_done = 1'b1;
    tick();
    ser_if.ser_done = 1'b0;
    chk("issue_done_grant", 32'(ser_if.grant), 32'h1);
    chk("issue_done_fcnt",  32'(frame_cnt), 0);
    tick();
    reset = 1'b1;
    tick();
    check_reset_vals("midrst");
    reset      = 1'b0;
    ser_if.req = 2'b00;

    // frame_div = 0 behaves as 1: back-to-back frames, one IDLE gap
    frame_div  = 16'd0;
    ser_if.req = 2'b01;
    do_reset();
    wait_start(w);
    chk("div0_first_lat", 32'(w), 2);
    run_frame(3, g, gcnt, scnt);
    chk("div0_gcnt", 32'(gcnt), 4);
    wait_start(w);
    chk("div0_gap", 32'(w), 1);
    run_frame(3, g, gcnt, scnt);
    wait_start(w);
    chk("div0_gap2", 32'(w), 1);
    ser_if.req = 2'b00;
    chk("div0_fcnt", 32'(frame_cnt), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_frame_sched.md
LED_FRAME_SCHED -- requirements
Module: led_frame_sched

Interface
REQ-001 SHALL have parameter DIV_W, default 16: width of the frame-period divider input.
REQ-002 SHALL have parameter TIMEOUT, default 8192: maximum cycles allowed in ACTIVE before abort.
REQ-003 SHALL have port clk  input  1: clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port frame_div  input  DIV_W: clk cycles between frame ticks; 0 treated as 1.
REQ-006 SHALL have port req  input  2: level frame requests, bit0 = scroller, bit1 = overlay.
REQ-007 SHALL have port scroll_en  input  1: enables shift advance after source-0 frames.
REQ-008 SHALL have port ser_busy  input  1: LED strip serializer busy.
REQ-009 SHALL have port ser_done  input  1: one-cycle end-of-frame pulse from serializer.
REQ-010 SHALL have port grant  output  2: one-hot grant, held for the whole frame.
REQ-011 SHALL have port ser_start  output  1: one-cycle frame start pulse.
REQ-012 SHALL have port ser_src  output  1: granted source index, stable from ser_start through ser_done.
REQ-013 SHALL have port shift  output  3: scroll shift 0..7, stable while a frame is active.
REQ-014 SHALL have port digit_sel  output  1: leading digit index, toggles at shift wrap.
REQ-015 SHALL have port frame_cnt  output  8: completed-frame counter, wraps 255->0.
REQ-016 SHALL have port timeout_err  output  1: sticky serializer-timeout flag.

Function
REQ-017 Prescaler SHALL count 0..max(frame_div,1)-1 and set internal frame_due on wrap; frame_due SHALL clear only when a grant issues, so extra ticks are absorbed, not queued.
REQ-018 States SHALL be IDLE, ISSUE, ACTIVE.
REQ-019 IDLE->ISSUE SHALL occur on the edge where frame_due=1, |req=1 and ser_busy=0. Otherwise it SHALL stay in IDLE.
REQ-020 On that edge, grant SHALL register one-hot and ser_src SHALL register.
REQ-021 In ISSUE, ser_start SHALL be 1 for exactly one cycle, which is the first cycle grant is high. ISSUE->ACTIVE SHALL be unconditional.
REQ-022 Arbitration SHALL be round-robin. With a single requester, that requester wins. With both requesting, the source not granted last wins. The last-grant pointer resets to source 1, so source 0 wins first.
REQ-023 In ACTIVE, ser_done=1 in cycle M SHALL cause the following at edge M+1: grant=0, frame_cnt+1, state IDLE.
REQ-024 Shift advance SHALL happen at that same edge only if the completed frame was source 0 and scroll_en=1. shift SHALL increment, 7 SHALL wrap to 0, and digit_sel SHALL toggle on the wrap.
REQ-025 A requester dropping req while granted SHALL NOT shorten the frame. grant SHALL be held until ser_done or timeout.
REQ-026 ser_done in IDLE or ISSUE SHALL be ignored.
REQ-027 Watchdog SHALL count cycles in ACTIVE. Reaching TIMEOUT SHALL at the next edge set timeout_err, clear grant and return to IDLE, with no frame_cnt or shift change.
REQ-028 ser_done and the timeout in the same cycle SHALL be treated as a normal completion.
REQ-029 timeout_err SHALL clear only on reset.
REQ-030 A frame_div change SHALL take effect at the next prescaler wrap. If the count is at or above the new value, the prescaler SHALL wrap immediately.

Reset
REQ-031 While reset=1 at an edge, SHALL set: state IDLE, grant=0, ser_start=0, ser_src=0, shift=0, digit_sel=0, frame_cnt=0, timeout_err=0, prescaler=0, frame_due=0, watchdog=0, last-grant pointer=1.
REQ-032 Reset mid-frame SHALL abort at the next edge with the same values; the serializer is reset by the same signal.

Structure
REQ-033 Package led_matrix_pkg SHALL hold the state enum, NUM_SRC=2, SHIFT_W=3, SHIFT_MAX=7, LED_COUNT=64 and DEFAULT_TIMEOUT=8192.
REQ-034 Sub-module frame_tick_gen SHALL implement the prescaler and frame_due latch.
REQ-035 The FSM, arbiter, shift/digit sequencing and watchdog SHALL stay in led_frame_sched.

Verification
REQ-036 Basic frame: frame_div=4, req=01, ser_done 10 cycles after ser_start -> ser_start pulses once, grant=01 for 11 cycles, frame_cnt=1, shift=1.
REQ-037 Round-robin: req=11 held for 4 frames -> grant sequence 01,10,01,10. Shift advances only after source-0 frames and equals 2 at the end.
REQ-038 Scroll wrap: scroll_en=1, source 0 only, 8 frames -> shift 1..7 then 0, digit_sel toggles 0->1 exactly once.
REQ-039 Timeout: TIMEOUT=16, ser_done withheld -> grant drops 17 cycles after entering ACTIVE, timeout_err=1 and stays set, frame_cnt unchanged.
REQ-040 Busy/reset: ser_busy=1 with frame_due=1 and req=01 -> no grant until ser_busy=0. Reset asserted mid-ACTIVE -> all outputs at reset values next cycle.
REQ-041 Divider edge: frame_div=0 with continuous req=01 and ser_done 3 cycles after ser_start -> back-to-back frames with a 1-cycle IDLE gap.
